// File: rtl/instruction_cache_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
// Latency: none (wires only).
// Backpressure: BUSYWAIT stalls the CPU; MEM_BUSYWAIT stalls the cache.
//
// Port summary
//   PC / INSTRUCTION / BUSYWAIT / FLUSH   CPU fetch side
//   MEM_READ / MEM_ADDRESS                block read request towards memory
//   MEM_READDATA / MEM_BUSYWAIT           block response from memory
//   HIT_COUNT / MISS_COUNT                performance counters
// The cache binds to the slave modport. The fetch stage, the instruction
// memory and the performance monitor together form the master side.
interface instruction_cache_if #(
   parameter int CNT_W = 32
);
   logic [31:0]      PC;
   logic [31:0]      INSTRUCTION;
   logic             BUSYWAIT;
   logic             FLUSH;
   logic             MEM_READ;
   logic [27:0]      MEM_ADDRESS;
   logic [127:0]     MEM_READDATA;
   logic             MEM_BUSYWAIT;
   logic [CNT_W-1:0] HIT_COUNT;
   logic [CNT_W-1:0] MISS_COUNT;

   modport slave (
      input  PC,
      input  FLUSH,
      input  MEM_READDATA,
      input  MEM_BUSYWAIT,
      output INSTRUCTION,
      output BUSYWAIT,
      output MEM_READ,
      output MEM_ADDRESS,
      output HIT_COUNT,
      output MISS_COUNT
   );

   modport master (
      output PC,
      output FLUSH,
      output MEM_READDATA,
      output MEM_BUSYWAIT,
      input  INSTRUCTION,
      input  BUSYWAIT,
      input  MEM_READ,
      input  MEM_ADDRESS,
      input  HIT_COUNT,
      input  MISS_COUNT
   );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache, 2**INDEX_W lines of 128 bits.
// Latency: hit returns the instruction in the same cycle; a miss costs the memory latency + 2.
// Backpressure: BUSYWAIT holds the CPU during a miss; MEM_BUSYWAIT holds the refill.
//
// Port summary
//   CLOCK        single clock, everything updates on the rising edge
//   RESET        synchronous, active-low
//   bus.PC       fetch byte address: [3:2] word, [4 +: INDEX_W] index, rest tag
//   bus.INSTRUCTION / bus.BUSYWAIT   instruction, valid while BUSYWAIT is low
//   bus.FLUSH    invalidate every line
//   bus.MEM_*    128-bit block read towards the instruction memory
//   bus.HIT_COUNT / bus.MISS_COUNT   saturating performance counters
module instruction_cache #(
   parameter int INDEX_W = 3,
   parameter int CNT_W   = 32
) (
   input logic                CLOCK,
   input logic                RESET,
   instruction_cache_if.slave bus
);
   localparam int NUM_SETS = 2 ** INDEX_W;
   localparam int TAG_W    = 28 - INDEX_W;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      FILL
   } state_t;

   // FSM and control state
   state_t              state;
   logic [27:0]         miss_addr;
   logic                mem_read;
   logic                busy_seen;
   logic                flush_pending;
   logic [CNT_W-1:0]    hit_count;
   logic [CNT_W-1:0]    miss_count;

   // Line storage. Only the valid bits need a reset value.
   logic [NUM_SETS-1:0] valid_bits;
   logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
   logic [127:0]        data_mem [NUM_SETS];

   // Lookup
   logic [INDEX_W-1:0]  pc_index;
   logic [TAG_W-1:0]    pc_tag;
   logic [1:0]          pc_word;
   logic [127:0]        line_data;
   logic                hit;
   logic                lookup_hit;

   // Refill target
   logic [INDEX_W-1:0]  fill_index;
   logic [TAG_W-1:0]    fill_tag;
   logic                flush_now;

   // Byte offset within the word never selects anything.
   logic                unused_pc_bits;

   assign pc_index       = bus.PC[4 +: INDEX_W];
   assign pc_tag         = bus.PC[31 -: TAG_W];
   assign pc_word        = bus.PC[3:2];
   assign unused_pc_bits = ^bus.PC[1:0];

   assign line_data  = data_mem[pc_index];
   assign hit        = valid_bits[pc_index] && (tag_mem[pc_index] == pc_tag);
   assign lookup_hit = (state == IDLE) && hit;

   assign fill_index = miss_addr[INDEX_W-1:0];
   assign fill_tag   = miss_addr[27 -: TAG_W];
   // A flush seen at any point of the miss, including the FILL cycle itself,
   // must also kill the line that is being written.
   assign flush_now  = flush_pending || bus.FLUSH;

   assign bus.INSTRUCTION = line_data[{pc_word, 5'd0} +: 32];
   assign bus.BUSYWAIT    = !RESET || !lookup_hit;
   assign bus.MEM_READ    = mem_read;
   assign bus.MEM_ADDRESS = miss_addr;
   assign bus.HIT_COUNT   = hit_count;
   assign bus.MISS_COUNT  = miss_count;

   // Control FSM. MEM_READ and MEM_ADDRESS are registered here so they stay
   // constant for the whole FETCH state regardless of what PC does.
   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         state         <= IDLE;
         valid_bits    <= '0;
         miss_addr     <= '0;
         mem_read      <= 1'b0;
         busy_seen     <= 1'b0;
         flush_pending <= 1'b0;
         hit_count     <= '0;
         miss_count    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.FLUSH) begin
                  valid_bits <= '0;
               end
               if (hit) begin
                  if (hit_count != {CNT_W{1'b1}}) begin
                     hit_count <= hit_count + CNT_W'(1);
                  end
               end else begin
                  miss_addr <= bus.PC[31:4];
                  mem_read  <= 1'b1;
                  busy_seen <= 1'b0;
                  state     <= FETCH;
                  if (miss_count != {CNT_W{1'b1}}) begin
                     miss_count <= miss_count + CNT_W'(1);
                  end
               end
            end

            FETCH: begin
               if (bus.FLUSH) begin
                  flush_pending <= 1'b1;
               end
               // Memory must first raise MEM_BUSYWAIT; a low level on entry
               // is left over from the previous transfer, not an answer.
               if (bus.MEM_BUSYWAIT) begin
                  busy_seen <= 1'b1;
               end else if (busy_seen) begin
                  mem_read <= 1'b0;
                  state    <= FILL;
               end
            end

            FILL: begin
               if (flush_now) begin
                  valid_bits <= '0;
               end else begin
                  valid_bits[fill_index] <= 1'b1;
               end
               flush_pending <= 1'b0;
               busy_seen     <= 1'b0;
               state         <= IDLE;
            end

            default: begin
               state    <= IDLE;
               mem_read <= 1'b0;
            end
         endcase
      end
   end

   // Tag and data arrays are written only in FILL. Reset blocks the write so
   // a response that arrives after an abandoned request cannot land anywhere.
   always_ff @(posedge CLOCK) begin
      if (RESET && (state == FILL)) begin
         tag_mem[fill_index]  <= fill_tag;
         data_mem[fill_index] <= bus.MEM_READDATA;
      end
   end
endmodule

// File: tb/tb_instruction_cache.sv
module tb_instruction_cache;
   localparam int MEM_LAT = 5;

   logic CLOCK;
   logic RESET;

   instruction_cache_if #(.CNT_W(32)) bus ();

   instruction_cache #(
      .INDEX_W(3),
      .CNT_W  (32)
   ) dut (
      .CLOCK(CLOCK),
      .RESET(RESET),
      .bus  (bus)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   int checks   = 0;
   int failures = 0;

   logic [27:0] req_q[$];

   // Block contents: word w of block a is {4'hC, a[23:0], 2'b00, w}.
   function automatic logic [127:0] block_of(input logic [27:0] a);
      logic [127:0] b;
      b = '0;
      for (int w = 0; w < 4; w++) begin
         b[32*w +: 32] = 32'hC000_0000 | {4'h0, a[23:0], 4'h0} | 32'(w);
      end
      return b;
   endfunction

   // Instruction memory: on a read request, raise MEM_BUSYWAIT for MEM_LAT
   // negedges, then drop it with the block on MEM_READDATA, held until the
   // next request.
   initial begin
      int          cnt;
      logic        active;
      logic [27:0] addr;
      cnt    = 0;
      active = 1'b0;
      addr   = '0;
      bus.MEM_BUSYWAIT = 1'b0;
      bus.MEM_READDATA = '0;
      forever begin
         @(negedge CLOCK);
         if (active) begin
            if (cnt > 1) begin
               cnt--;
            end else begin
               bus.MEM_BUSYWAIT = 1'b0;
               bus.MEM_READDATA = block_of(addr);
               active = 1'b0;
            end
         end else if (bus.MEM_READ === 1'b1) begin
            active = 1'b1;
            cnt    = MEM_LAT;
            addr   = bus.MEM_ADDRESS;
            req_q.push_back(addr);
            bus.MEM_BUSYWAIT = 1'b1;
            bus.MEM_READDATA = {4{32'h5A5A_5A5A}};
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   // Tick until BUSYWAIT falls (bounded). Also flags MEM_READ dropping
   // while memory is still busy.
   task automatic wait_ready(output int n, output logic early_drop);
      n = 0;
      early_drop = 1'b0;
      while (bus.BUSYWAIT !== 1'b0 && n < 60) begin
         tick();
         n++;
         if (bus.MEM_BUSYWAIT === 1'b1 && bus.MEM_READ !== 1'b1) early_drop = 1'b1;
      end
   endtask

   task automatic do_miss(input string name, input logic [31:0] pc,
                          input logic [27:0] exp_addr, input logic [31:0] exp_word);
      int   n;
      logic drop;
      bus.PC = pc;
      #1;
      check({name, " miss busy"}, 64'(bus.BUSYWAIT), 64'(1));
      tick();
      check({name, " mem_read"}, 64'(bus.MEM_READ), 64'(1));
      check({name, " mem_addr"}, 64'(bus.MEM_ADDRESS), 64'(exp_addr));
      wait_ready(n, drop);
      check({name, " penalty"}, 64'(n), 64'(MEM_LAT + 2));
      check({name, " read held"}, 64'(drop), 64'(0));
      check({name, " instr"}, 64'(bus.INSTRUCTION), 64'(exp_word));
      check({name, " read low"}, 64'(bus.MEM_READ), 64'(0));
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] exp_instr;
      logic [31:0] exp_hits;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int   n;
      logic drop;

      vecs[0] = '{32'h0000_0000, 32'hC000_0000, 32'd1};
      vecs[1] = '{32'h0000_0004, 32'hC000_0001, 32'd2};
      vecs[2] = '{32'h0000_0008, 32'hC000_0002, 32'd3};
      vecs[3] = '{32'h0000_000C, 32'hC000_0003, 32'd4};
      vecs[4] = '{32'h0000_0003, 32'hC000_0000, 32'd5};
      vecs[5] = '{32'h0000_000E, 32'hC000_0003, 32'd6};

      RESET     = 1'b0;
      bus.PC    = 32'h0;
      bus.FLUSH = 1'b0;
      repeat (3) tick();
      check("reset busywait", 64'(bus.BUSYWAIT), 64'(1));
      check("reset mem_read", 64'(bus.MEM_READ), 64'(0));
      check("reset mem_addr", 64'(bus.MEM_ADDRESS), 64'(0));
      check("reset hits", 64'(bus.HIT_COUNT), 64'(0));
      check("reset misses", 64'(bus.MISS_COUNT), 64'(0));

      // Cold miss on block 0
      RESET = 1'b1;
      do_miss("cold", 32'h0, 28'h0, 32'hC000_0000);
      check("cold misses", 64'(bus.MISS_COUNT), 64'(1));
      check("cold hits", 64'(bus.HIT_COUNT), 64'(0));

      // Hits within block 0, one per cycle
      for (int i = 0; i < 6; i++) begin
         bus.PC = vecs[i].pc;
         #1;
         check($sformatf("hit%0d busy", i), 64'(bus.BUSYWAIT), 64'(0));
         check($sformatf("hit%0d instr", i), 64'(bus.INSTRUCTION), 64'(vecs[i].exp_instr));
         tick();
         check($sformatf("hit%0d count", i), 64'(bus.HIT_COUNT), 64'(vecs[i].exp_hits));
         check($sformatf("hit%0d mem_read", i), 64'(bus.MEM_READ), 64'(0));
      end
      check("hits misses", 64'(bus.MISS_COUNT), 64'(1));

      // Conflict eviction on index 0
      do_miss("evict80", 32'h80, 28'h8, 32'hC000_0080);
      do_miss("evict00", 32'h0, 28'h0, 32'hC000_0000);
      check("evict misses", 64'(bus.MISS_COUNT), 64'(3));
      check("evict hits", 64'(bus.HIT_COUNT), 64'(6));
      check("evict reqs", 64'(req_q.size()), 64'(3));
      check("evict req1", 64'(req_q[1]), 64'(28'h8));

      // PC moves while the miss on 0x10 is outstanding
      bus.PC = 32'h10;
      #1;
      tick();
      check("pcchg addr", 64'(bus.MEM_ADDRESS), 64'(28'h1));
      bus.PC = 32'h20;
      tick();
      tick();
      check("pcchg addr held", 64'(bus.MEM_ADDRESS), 64'(28'h1));
      check("pcchg busy", 64'(bus.BUSYWAIT), 64'(1));
      wait_ready(n, drop);
      check("pcchg cycles", 64'(n), 64'(13));
      check("pcchg reqs", 64'(req_q.size()), 64'(5));
      check("pcchg req first", 64'(req_q[3]), 64'(28'h1));
      check("pcchg req second", 64'(req_q[4]), 64'(28'h2));
      check("pcchg instr", 64'(bus.INSTRUCTION), 64'(32'hC000_0020));
      check("pcchg misses", 64'(bus.MISS_COUNT), 64'(5));
      bus.PC = 32'h10;
      #1;
      check("pcchg line1 hit", 64'(bus.BUSYWAIT), 64'(0));
      check("pcchg line1 instr", 64'(bus.INSTRUCTION), 64'(32'hC000_0010));

      // Flush while idle
      bus.FLUSH = 1'b1;
      #1;
      check("flush idle hit", 64'(bus.BUSYWAIT), 64'(0));
      tick();
      bus.FLUSH = 1'b0;
      #1;
      check("flush idle miss", 64'(bus.BUSYWAIT), 64'(1));
      do_miss("refill10", 32'h10, 28'h1, 32'hC000_0010);
      bus.PC = 32'h20;
      #1;
      check("flush idle miss20", 64'(bus.BUSYWAIT), 64'(1));
      do_miss("refill20", 32'h20, 28'h2, 32'hC000_0020);

      // Flush while a miss is in FETCH
      bus.PC = 32'h30;
      #1;
      tick();
      bus.FLUSH = 1'b1;
      tick();
      bus.FLUSH = 1'b0;
      wait_ready(n, drop);
      check("flush fetch cycles", 64'(n), 64'(14));
      check("flush fetch reqs", 64'(req_q.size()), 64'(9));
      check("flush fetch req a", 64'(req_q[7]), 64'(28'h3));
      check("flush fetch req b", 64'(req_q[8]), 64'(28'h3));
      check("flush fetch instr", 64'(bus.INSTRUCTION), 64'(32'hC000_0030));
      bus.PC = 32'h20;
      #1;
      check("flush fetch miss20", 64'(bus.BUSYWAIT), 64'(1));
      do_miss("post flush 20", 32'h20, 28'h2, 32'hC000_0020);

      // Reset while a request is outstanding
      bus.PC = 32'h40;
      #1;
      tick();
      tick();
      tick();
      check("rst mid read", 64'(bus.MEM_READ), 64'(1));
      RESET = 1'b0;
      tick();
      check("rst mem_read", 64'(bus.MEM_READ), 64'(0));
      check("rst mem_addr", 64'(bus.MEM_ADDRESS), 64'(0));
      check("rst hits", 64'(bus.HIT_COUNT), 64'(0));
      check("rst misses", 64'(bus.MISS_COUNT), 64'(0));
      check("rst busy", 64'(bus.BUSYWAIT), 64'(1));
      repeat (6) tick();
      check("rst read stays low", 64'(bus.MEM_READ), 64'(0));
      bus.PC = 32'h20;
      RESET = 1'b1;
      #1;
      check("rst line20 invalid", 64'(bus.BUSYWAIT), 64'(1));
      tick();
      check("rst new miss count", 64'(bus.MISS_COUNT), 64'(1));
      check("rst new miss addr", 64'(bus.MEM_ADDRESS), 64'(28'h2));
      wait_ready(n, drop);
      check("rst new penalty", 64'(n), 64'(MEM_LAT + 2));
      check("rst new instr", 64'(bus.INSTRUCTION), 64'(32'hC000_0020));
      check("rst total reqs", 64'(req_q.size()), 64'(12));
      bus.PC = 32'h40;
      #1;
      check("rst line40 invalid", 64'(bus.BUSYWAIT), 64'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
